// File: rtl/toccata_i2s_tx.sv
// toccata_i2s_tx
// Stereo I2S transmitter fed by the volume stage. A one-deep holding buffer
// takes a signed 16-bit left/right pair through a valid/ready handshake. The
// serialiser derives BCLK/LRCLK from clk and shifts the pair out MSB-first in
// standard I2S framing: one BCLK of delay after each LRCLK edge, 32-bit slots,
// 64 BCLKs per frame. Frame loads and underruns are reported as 1-cycle pulses.
//
// Parameters
//   CLK_DIV       clk cycles per BCLK half-period (>= 1)
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   enable        serialiser run; low holds the serialiser idle
//   sample_left   signed left sample
//   sample_right  signed right sample
//   sample_valid  sample pair valid
//   sample_ready  holding buffer empty; pair taken when valid & ready
//   i2s_bclk      bit clock
//   i2s_lrclk     word select (0 = left slot, 1 = right slot)
//   i2s_sdata     serial data, updated together with BCLK falling
//   frame_start   1-cycle pulse when a frame is loaded
//   underrun      1-cycle pulse when a frame is loaded from an empty buffer
module toccata_i2s_tx #(
    parameter int CLK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] sample_left,
    input  logic [15:0] sample_right,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata,
    output logic        frame_start,
    output logic        underrun
);

    localparam int DATA_W = 16;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]         div_cnt_q, div_cnt_d;
    logic [5:0]               bit_cnt_q, bit_cnt_d;
    logic [5:0]               bit_cnt_nx;
    logic                     bclk_q, bclk_d;
    logic                     lrclk_q, lrclk_d;
    logic                     sdata_q, sdata_d;
    logic                     fs_q, fs_d;
    logic                     ur_q, ur_d;
    logic                     ready_q, ready_d;
    logic                     hold_full_q, hold_full_d;
    logic signed [DATA_W-1:0] hold_l_q, hold_l_d;
    logic signed [DATA_W-1:0] hold_r_q, hold_r_d;
    logic [63:0]              frame_q, frame_d;

    logic accept;
    logic div_wrap;
    logic fall;
    logic load;

    // Frame bit p is what goes on the wire when bit_cnt == p. Bit 0 and bit 32
    // are the one-BCLK I2S delay slots; the samples sit MSB-first right after.
    function automatic logic [63:0] build_frame(input logic signed [DATA_W-1:0] l,
                                                input logic signed [DATA_W-1:0] r);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < DATA_W; i++) begin
            f[6'(16 - i)] = l[4'(i)];
            f[6'(48 - i)] = r[4'(i)];
        end
        return f;
    endfunction

    assign accept     = sample_valid & ready_q;
    assign div_wrap   = enable && (div_cnt_q == DIV_LAST);
    assign fall       = div_wrap && bclk_q;
    assign bit_cnt_nx = bit_cnt_q + 6'd1;
    assign load       = fall && (bit_cnt_nx == 6'd0);

    always_comb begin
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        bclk_d      = bclk_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        fs_d        = 1'b0;
        ur_d        = 1'b0;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        frame_d     = frame_q;

        if (!enable) begin
            // Idle looks exactly like post-reset so re-enable restarts cleanly.
            div_cnt_d = '0;
            bit_cnt_d = 6'd63;
            bclk_d    = 1'b0;
            lrclk_d   = 1'b0;
            sdata_d   = 1'b0;
        end else begin
            div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
            if (div_wrap) begin
                bclk_d = ~bclk_q;
            end
            if (load) begin
                // Load uses the buffer state from before this cycle's accept,
                // so a pair arriving in the load cycle waits for the next frame.
                frame_d = hold_full_q ? build_frame(hold_l_q, hold_r_q) : '0;
                fs_d    = 1'b1;
                ur_d    = !hold_full_q;
                if (hold_full_q) begin
                    hold_full_d = 1'b0;
                end
            end
            if (fall) begin
                bit_cnt_d = bit_cnt_nx;
                lrclk_d   = bit_cnt_nx[5];
                sdata_d   = frame_d[bit_cnt_nx];
            end
        end

        // The buffer keeps working while the serialiser is idle so a pair can
        // be preloaded. accept implies the buffer was empty, so it never
        // collides with the clear above.
        if (accept) begin
            hold_l_d    = $signed(sample_left);
            hold_r_d    = $signed(sample_right);
            hold_full_d = 1'b1;
        end

        ready_d = !hold_full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q   <= '0;
            bit_cnt_q   <= 6'd63;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            fs_q        <= 1'b0;
            ur_q        <= 1'b0;
            ready_q     <= 1'b0;
            hold_full_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            fs_q        <= fs_d;
            ur_q        <= ur_d;
            ready_q     <= ready_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Sample and frame storage carry no reset; hold_full gates every use.
    always_ff @(posedge clk) begin
        hold_l_q <= hold_l_d;
        hold_r_q <= hold_r_d;
        frame_q  <= frame_d;
    end

    assign sample_ready = ready_q;
    assign i2s_bclk     = bclk_q;
    assign i2s_lrclk    = lrclk_q;
    assign i2s_sdata    = sdata_q;
    assign frame_start  = fs_q;
    assign underrun     = ur_q;

endmodule

// File: tb/tb_toccata_i2s_tx.sv
// Testbench for toccata_i2s_tx with CLK_DIV = 2 (BCLK = 4 clk, frame = 256 clk).
// The reference model tracks elapsed enabled clk edges since restart and
// derives BCLK/LRCLK/data position arithmetically from that count.
module tb_toccata_i2s_tx;

    localparam int CLK_DIV = 2;
    localparam int BP      = 2 * CLK_DIV;

    logic        clk          = 1'b0;
    logic        rst          = 1'b1;
    logic        enable       = 1'b1;
    logic [15:0] sample_left  = '0;
    logic [15:0] sample_right = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic        frame_start;
    logic        underrun;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    toccata_i2s_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrclk    (i2s_lrclk),
        .i2s_sdata    (i2s_sdata),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    // Reference model: m_n = enabled edges since restart.
    int          m_n     = 0;
    logic        m_full  = 1'b0;
    logic        m_ready = 1'b0;
    logic        m_fs    = 1'b0;
    logic        m_ur    = 1'b0;
    logic [15:0] m_bl = '0, m_br = '0, m_cl = '0, m_cr = '0;
    int          n_nx;
    logic        m_ld;
    logic        m_acc;

    assign n_nx  = enable ? m_n + 1 : 0;
    assign m_ld  = enable && (n_nx % BP == 0) && ((n_nx / BP - 1) % 64 == 0);
    assign m_acc = sample_valid && m_ready;

    always @(posedge clk) begin
        if (rst) begin
            m_n     <= 0;
            m_full  <= 1'b0;
            m_ready <= 1'b0;
            m_fs    <= 1'b0;
            m_ur    <= 1'b0;
        end else begin
            m_n  <= n_nx;
            m_fs <= m_ld;
            m_ur <= m_ld && !m_full;
            if (m_ld) begin
                m_cl <= m_full ? m_bl : 16'h0000;
                m_cr <= m_full ? m_br : 16'h0000;
            end
            if (m_acc) begin
                m_bl <= sample_left;
                m_br <= sample_right;
            end
            m_full  <= m_acc ? 1'b1 : (m_ld ? 1'b0 : m_full);
            m_ready <= !(m_acc ? 1'b1 : (m_ld ? 1'b0 : m_full));
        end
    end

    function automatic logic [5:0] exp_out();
        int k, p;
        logic b, lr, sd;
        k  = m_n / BP;
        b  = ((m_n / CLK_DIV) % 2) != 0;
        lr = 1'b0;
        sd = 1'b0;
        if (k > 0) begin
            p  = (k - 1) % 64;
            lr = (p >= 32);
            if (p >= 1 && p <= 16) sd = m_cl[4'(16 - p)];
            else if (p >= 33 && p <= 48) sd = m_cr[4'(48 - p)];
        end
        return {b, lr, sd, m_fs, m_ur, m_ready};
    endfunction

    function automatic logic [5:0] obs();
        return {i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, sample_ready};
    endfunction

    // Capture of the serial words per frame index, sampled right after each fall.
    logic [15:0] cap_l [4];
    logic [15:0] cap_r [4];
    logic        cap_x [4];
    int          cap_k, cap_p, cap_f;
    logic        cap_ev;

    assign cap_k  = m_n / BP;
    assign cap_p  = (cap_k - 1) % 64;
    assign cap_f  = (cap_k - 1) / 64;
    assign cap_ev = (m_n > 0) && (m_n % BP == 0) && (cap_f < 4);

    always @(negedge clk) begin
        if (cap_ev) begin
            if (cap_p == 0) begin
                cap_l[2'(cap_f)] <= '0;
                cap_r[2'(cap_f)] <= '0;
                cap_x[2'(cap_f)] <= i2s_sdata;
            end else if (cap_p <= 16) begin
                cap_l[2'(cap_f)][4'(16 - cap_p)] <= i2s_sdata;
            end else if (cap_p >= 33 && cap_p <= 48) begin
                cap_r[2'(cap_f)][4'(48 - cap_p)] <= i2s_sdata;
            end else begin
                cap_x[2'(cap_f)] <= cap_x[2'(cap_f)] | i2s_sdata;
            end
        end
    end

    task automatic do_reset();
        rst          = 1'b1;
        enable       = 1'b1;
        sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        enable       = 1'b1;
        sample_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun} !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_outputs: got %b want 00000",
                         {i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (sample_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_release: got %b want 1", sample_ready);
        end
        n_cmp++;
        if (obs() !== exp_out()) begin
            n_bad++;
            $display("FAIL reset_model: got %b want %b", obs(), exp_out());
        end
    endtask

    task automatic test_single_pair();
        int   fs_cnt, ur_cnt, first_fs;
        logic pend;
        do_reset();
        sample_left  = 16'h8001;
        sample_right = 16'h7FFE;
        sample_valid = 1'b1;
        fs_cnt = 0; ur_cnt = 0; first_fs = -1; pend = 1'b0;
        for (int i = 1; i <= 264; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== exp_out()) begin
                n_bad++;
                $display("FAIL single_pair cyc %0d: got %b want %b", i, obs(), exp_out());
            end
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = i;
            end
            if (underrun === 1'b1) ur_cnt++;
            if (pend) begin sample_valid = 1'b0; pend = 1'b0; end
            pend = sample_valid && sample_ready;
        end
        n_cmp++;
        if (first_fs != BP) begin
            n_bad++; $display("FAIL single_first_fs: got %0d want %0d", first_fs, BP);
        end
        n_cmp++;
        if (fs_cnt != 2 || ur_cnt != 1) begin
            n_bad++; $display("FAIL single_pulses: got fs=%0d ur=%0d want fs=2 ur=1", fs_cnt, ur_cnt);
        end
        n_cmp++;
        if (cap_l[0] !== 16'h8001 || cap_r[0] !== 16'h7FFE || cap_x[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL single_words: got L=%h R=%h pad=%b want L=8001 R=7ffe pad=0",
                     cap_l[0], cap_r[0], cap_x[0]);
        end
    endtask

    task automatic test_underrun();
        int   fs_cnt, ur_cnt, first_fs, last_fs, sd_ones, n_tog, last_tog, bad_iv;
        logic prev_lr;
        do_reset();
        fs_cnt = 0; ur_cnt = 0; first_fs = -1; last_fs = -1; sd_ones = 0;
        n_tog = 0; last_tog = -1; bad_iv = 0; prev_lr = 1'b0;
        for (int i = 1; i <= 520; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== exp_out()) begin
                n_bad++;
                $display("FAIL underrun cyc %0d: got %b want %b", i, obs(), exp_out());
            end
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = i;
                last_fs = i;
            end
            if (underrun === 1'b1) ur_cnt++;
            if (i2s_sdata !== 1'b0) sd_ones++;
            if (i2s_lrclk !== prev_lr) begin
                if (last_tog >= 0 && (i - last_tog) != 128) bad_iv++;
                last_tog = i;
                n_tog++;
                prev_lr = i2s_lrclk;
            end
        end
        n_cmp++;
        if (fs_cnt != 3 || ur_cnt != 3) begin
            n_bad++; $display("FAIL underrun_pulses: got fs=%0d ur=%0d want 3 and 3", fs_cnt, ur_cnt);
        end
        n_cmp++;
        if (last_fs - first_fs != 512) begin
            n_bad++; $display("FAIL underrun_period: got %0d want 512", last_fs - first_fs);
        end
        n_cmp++;
        if (sd_ones != 0) begin
            n_bad++; $display("FAIL underrun_sdata: got %0d ones want 0", sd_ones);
        end
        n_cmp++;
        if (n_tog != 4 || bad_iv != 0) begin
            n_bad++; $display("FAIL underrun_lrclk: got toggles=%0d bad_intervals=%0d want 4 and 0", n_tog, bad_iv);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] al, ar, bl, br;
        int          stage, a_edge, b_edge, fs_cnt, ur_cnt;
        logic        pend;
        al = 16'($urandom); ar = 16'($urandom);
        bl = 16'($urandom); br = 16'($urandom);
        do_reset();
        sample_left = al; sample_right = ar; sample_valid = 1'b1;
        stage = 0; a_edge = -1; b_edge = -1; fs_cnt = 0; ur_cnt = 0; pend = 1'b0;
        for (int i = 1; i <= 513; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== exp_out()) begin
                n_bad++;
                $display("FAIL back_to_back cyc %0d: got %b want %b", i, obs(), exp_out());
            end
            if (frame_start === 1'b1) fs_cnt++;
            if (underrun === 1'b1) ur_cnt++;
            if (pend) begin
                pend = 1'b0;
                if (stage == 0) begin
                    a_edge = i; stage = 1;
                    sample_left = bl; sample_right = br;
                end else begin
                    b_edge = i; stage = 2;
                    sample_valid = 1'b0;
                end
            end
            pend = sample_valid && sample_ready;
        end
        n_cmp++;
        if (a_edge != 2 || b_edge != BP + 1) begin
            n_bad++; $display("FAIL b2b_accept_edges: got A=%0d B=%0d want A=2 B=%0d", a_edge, b_edge, BP + 1);
        end
        n_cmp++;
        if (fs_cnt != 2 || ur_cnt != 0) begin
            n_bad++; $display("FAIL b2b_pulses: got fs=%0d ur=%0d want fs=2 ur=0", fs_cnt, ur_cnt);
        end
        n_cmp++;
        if (cap_l[0] !== al || cap_r[0] !== ar || cap_l[1] !== bl || cap_r[1] !== br) begin
            n_bad++;
            $display("FAIL b2b_words: got %h %h %h %h want %h %h %h %h",
                     cap_l[0], cap_r[0], cap_l[1], cap_r[1], al, ar, bl, br);
        end
    endtask

    task automatic test_collision();
        logic [15:0] pl, pr;
        int          fs_cnt, ur_cnt;
        logic        ur_at_load;
        pl = 16'($urandom) | 16'h0100; pr = 16'($urandom) | 16'h0001;
        do_reset();
        sample_left = pl; sample_right = pr;
        fs_cnt = 0; ur_cnt = 0; ur_at_load = 1'b0;
        for (int i = 1; i <= 513; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== exp_out()) begin
                n_bad++;
                $display("FAIL collision cyc %0d: got %b want %b", i, obs(), exp_out());
            end
            if (frame_start === 1'b1) fs_cnt++;
            if (underrun === 1'b1) ur_cnt++;
            if (i == BP && underrun === 1'b1) ur_at_load = 1'b1;
            sample_valid = (i == BP - 1);
        end
        n_cmp++;
        if (ur_at_load !== 1'b1 || ur_cnt != 1 || fs_cnt != 2) begin
            n_bad++;
            $display("FAIL collision_pulses: got ur_at_load=%b ur=%0d fs=%0d want 1 1 2", ur_at_load, ur_cnt, fs_cnt);
        end
        n_cmp++;
        if (cap_l[0] !== 16'h0 || cap_r[0] !== 16'h0 || cap_l[1] !== pl || cap_r[1] !== pr) begin
            n_bad++;
            $display("FAIL collision_words: got %h %h %h %h want 0000 0000 %h %h",
                     cap_l[0], cap_r[0], cap_l[1], cap_r[1], pl, pr);
        end
    endtask

    task automatic test_mid_reset();
        int   stage, first_fs, first_ur;
        logic pend;
        do_reset();
        sample_left = 16'($urandom); sample_right = 16'($urandom); sample_valid = 1'b1;
        stage = 0; pend = 1'b0;
        for (int i = 1; i <= 84; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== exp_out()) begin
                n_bad++;
                $display("FAIL mid_reset_pre cyc %0d: got %b want %b", i, obs(), exp_out());
            end
            if (pend) begin
                pend = 1'b0;
                if (stage == 0) begin
                    stage = 1;
                    sample_left = 16'($urandom) | 16'h8000; sample_right = 16'($urandom) | 16'h4000;
                end else begin
                    stage = 2;
                    sample_valid = 1'b0;
                end
            end
            pend = sample_valid && sample_ready;
        end
        rst = 1'b1; sample_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun} !== 5'b0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got %b want 00000",
                     {i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun});
        end
        rst = 1'b0;
        first_fs = -1; first_ur = -1;
        for (int i = 1; i <= 264; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== exp_out()) begin
                n_bad++;
                $display("FAIL mid_reset_post cyc %0d: got %b want %b", i, obs(), exp_out());
            end
            if (frame_start === 1'b1 && first_fs < 0) first_fs = i;
            if (underrun === 1'b1 && first_ur < 0) first_ur = i;
        end
        n_cmp++;
        if (first_fs != BP || first_ur != BP) begin
            n_bad++; $display("FAIL mid_reset_restart: got fs@%0d ur@%0d want %0d", first_fs, first_ur, BP);
        end
        n_cmp++;
        if (cap_l[0] !== 16'h0 || cap_r[0] !== 16'h0) begin
            n_bad++; $display("FAIL mid_reset_flushed: got L=%h R=%h want 0000 0000", cap_l[0], cap_r[0]);
        end
    endtask

    task automatic test_enable();
        logic [15:0] cl, cr;
        int          bclk_hi, first_fs, ur_cnt;
        logic        pend;
        cl = 16'($urandom); cr = 16'($urandom);
        do_reset();
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== exp_out()) begin
                n_bad++;
                $display("FAIL enable_run cyc %0d: got %b want %b", i, obs(), exp_out());
            end
        end
        enable = 1'b0;
        sample_left = cl; sample_right = cr; sample_valid = 1'b1;
        bclk_hi = 0; pend = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== exp_out()) begin
                n_bad++;
                $display("FAIL enable_off cyc %0d: got %b want %b", i, obs(), exp_out());
            end
            if (i2s_bclk !== 1'b0) bclk_hi++;
            if (pend) begin sample_valid = 1'b0; pend = 1'b0; end
            pend = sample_valid && sample_ready;
        end
        enable = 1'b1;
        first_fs = -1; ur_cnt = 0;
        for (int i = 1; i <= 260; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs() !== exp_out()) begin
                n_bad++;
                $display("FAIL enable_resume cyc %0d: got %b want %b", i, obs(), exp_out());
            end
            if (frame_start === 1'b1 && first_fs < 0) first_fs = i;
            if (underrun === 1'b1) ur_cnt++;
        end
        n_cmp++;
        if (bclk_hi != 0) begin
            n_bad++; $display("FAIL enable_bclk_idle: got %0d high cycles want 0", bclk_hi);
        end
        n_cmp++;
        if (first_fs != BP || ur_cnt != 0) begin
            n_bad++; $display("FAIL enable_restart: got fs@%0d ur=%0d want fs@%0d ur=0", first_fs, ur_cnt, BP);
        end
        n_cmp++;
        if (cap_l[0] !== cl || cap_r[0] !== cr) begin
            n_bad++; $display("FAIL enable_preload: got L=%h R=%h want %h %h", cap_l[0], cap_r[0], cl, cr);
        end
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_underrun();
        test_back_to_back();
        test_collision();
        test_mid_reset();
        test_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
